// File: rtl/btb_update_controller.sv
// Branch resolution / BTB write-side controller: mispredict redirect, wrong-path flush, buffered BTB writes.
// Optional statistics counters are enabled with `define BTB_UPDATE_STATS_EN.
module btb_update_controller #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_hit_i,
  input  logic [31:0] ex_pred_target_i,
  input  logic        btb_wr_ready_i,
  output logic        update_btb_address_o,
  output logic [31:0] pc_ex_o,
  output logic [31:0] btb_address_value_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t         state_p1;
  logic [CW-1:0]  flush_cnt_p1;
  logic           redirect_vld_p1;
  logic [31:0]    redirect_pc_p1;
  logic           flush_p1;

  logic [AW:0]    wr_ptr_p1;
  logic [AW:0]    rd_ptr_p1;
  logic [63:0]    fifo_mem [DEPTH];

  logic           empty;
  logic           full;
  logic           accept;
  logic           mispredict;
  logic           push;
  logic           pop;
  logic [63:0]    wr_data;
  logic [63:0]    head;

  // ---- EX stage: resolve the branch against its prediction ----
  assign empty      = (wr_ptr_p1 == rd_ptr_p1);
  assign full       = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                      (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
  assign accept     = ex_valid_i && !full && (state_p1 == IDLE);
  assign mispredict = (ex_taken_i != ex_pred_hit_i) ||
                      (ex_taken_i && ex_pred_hit_i && (ex_target_i != ex_pred_target_i));
  // A zero target cannot be stored: zero is the BTB's miss encoding.
  assign push       = accept &&
                      ((ex_taken_i && mispredict && (ex_target_i != 32'h0)) ||
                       (!ex_taken_i && ex_pred_hit_i));
  assign pop        = !empty && btb_wr_ready_i;
  assign wr_data    = {ex_pc_i, (ex_taken_i ? ex_target_i : 32'h0)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
    end else begin
      if (push) wr_ptr_p1 <= wr_ptr_p1 + (AW+1)'(1);
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_p1[AW-1:0]] <= wr_data;
  end

  // ---- P1 stage: redirect / flush control ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1        <= IDLE;
      flush_cnt_p1    <= '0;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= 32'h0;
      flush_p1        <= 1'b0;
    end else begin
      redirect_vld_p1 <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (accept && mispredict) begin
            state_p1        <= FLUSH;
            flush_cnt_p1    <= CW'(FLUSH_CYCLES - 1);
            redirect_vld_p1 <= 1'b1;
            redirect_pc_p1  <= ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
            flush_p1        <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_p1 == '0) begin
            state_p1 <= IDLE;
            flush_p1 <= 1'b0;
          end else begin
            flush_cnt_p1 <= flush_cnt_p1 - CW'(1);
          end
        end
        default: begin
          state_p1 <= IDLE;
          flush_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Head is gated with empty so stale, unreset storage never reaches the BTB port.
  assign head                 = empty ? 64'h0 : fifo_mem[rd_ptr_p1[AW-1:0]];
  assign update_btb_address_o = !empty;
  assign pc_ex_o              = head[63:32];
  assign btb_address_value_o  = head[31:0];
  assign redirect_o           = redirect_vld_p1;
  assign redirect_pc_o        = redirect_pc_p1;
  assign flush_o              = flush_p1;
  assign stall_o              = full;

`ifdef BTB_UPDATE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stat_br_p1;
  logic [31:0] stat_mis_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_br_p1  <= 32'h0;
      stat_mis_p1 <= 32'h0;
    end else if (accept) begin
      stat_br_p1 <= sat_inc(stat_br_p1);
      if (mispredict) stat_mis_p1 <= sat_inc(stat_mis_p1);
    end
  end

  assign stat_branches_o    = stat_br_p1;
  assign stat_mispredicts_o = stat_mis_p1;
`else
  assign stat_branches_o    = 32'h0;
  assign stat_mispredicts_o = 32'h0;
`endif

endmodule

// File: tb/tb_btb_update_controller.sv
// Bench for btb_update_controller: directed test-plan steps plus random traffic against a queue-based model.
module tb_btb_update_controller;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_hit_i;
  logic [31:0] ex_pred_target_i;
  logic        btb_wr_ready_i;
  logic        update_btb_address_o;
  logic [31:0] pc_ex_o;
  logic [31:0] btb_address_value_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        stall_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispredicts_o;

  btb_update_controller #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .ex_valid_i           (ex_valid_i),
    .ex_pc_i              (ex_pc_i),
    .ex_taken_i           (ex_taken_i),
    .ex_target_i          (ex_target_i),
    .ex_pred_hit_i        (ex_pred_hit_i),
    .ex_pred_target_i     (ex_pred_target_i),
    .btb_wr_ready_i       (btb_wr_ready_i),
    .update_btb_address_o (update_btb_address_o),
    .pc_ex_o              (pc_ex_o),
    .btb_address_value_o  (btb_address_value_o),
    .redirect_o           (redirect_o),
    .redirect_pc_o        (redirect_pc_o),
    .flush_o              (flush_o),
    .stall_o              (stall_o),
    .stat_branches_o      (stat_branches_o),
    .stat_mispredicts_o   (stat_mispredicts_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writes as a queue, flush as cycles remaining.
  logic [63:0] mq[$];
  int          m_flush_left;
  bit          m_redir;
  logic [31:0] m_redir_pc;
  int unsigned m_br;
  int unsigned m_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush_left = 0;
    m_redir      = 0;
    m_redir_pc   = 32'h0;
    m_br         = 0;
    m_mis        = 0;
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    h = (mq.size() != 0) ? mq[0] : 64'h0;
    check("stall", stall_o, (mq.size() == DEPTH));
    check("wr_valid", update_btb_address_o, (mq.size() != 0));
    check("wr_pc", pc_ex_o, h[63:32]);
    check("wr_value", btb_address_value_o, h[31:0]);
    check("redirect", redirect_o, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc_o, m_redir_pc);
    check("flush", flush_o, (m_flush_left > 0));
`ifdef BTB_UPDATE_STATS_EN
    check("stat_br", stat_branches_o, m_br);
    check("stat_mis", stat_mispredicts_o, m_mis);
`else
    check("stat_br", stat_branches_o, 0);
    check("stat_mis", stat_mispredicts_o, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_valid"}, update_btb_address_o, 0);
    check({tag, "_wr_pc"}, pc_ex_o, 0);
    check({tag, "_wr_value"}, btb_address_value_o, 0);
    check({tag, "_redirect"}, redirect_o, 0);
    check({tag, "_redirect_pc"}, redirect_pc_o, 0);
    check({tag, "_flush"}, flush_o, 0);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_stat_br"}, stat_branches_o, 0);
    check({tag, "_stat_mis"}, stat_mispredicts_o, 0);
  endtask

  // Called at a negedge: drive one cycle of inputs, check, advance model, end at next negedge.
  task automatic step(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit hit, input logic [31:0] pt, input bit rdy);
    bit          acc, mis, full;
    logic [31:0] seq_pc;
    ex_valid_i       = v;
    ex_pc_i          = pc;
    ex_taken_i       = tk;
    ex_target_i      = tg;
    ex_pred_hit_i    = hit;
    ex_pred_target_i = pt;
    btb_wr_ready_i   = rdy;
    #1;
    check_outputs();
    full = (mq.size() == DEPTH);
    acc  = v && !full && (m_flush_left == 0);
    mis  = (tk != hit) || (tk && hit && (tg != pt));
    seq_pc = pc + 32'd4;
    if (m_flush_left > 0) m_flush_left--;
    m_redir = 0;
    if (acc) begin
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mis) begin
        if (m_mis != 32'hFFFF_FFFF) m_mis++;
        m_redir      = 1;
        m_redir_pc   = tk ? tg : seq_pc;
        m_flush_left = FLUSH_CYCLES;
      end
    end
    if ((mq.size() != 0) && rdy) void'(mq.pop_front());
    if (acc && tk && mis && (tg != 0)) mq.push_back({pc, tg});
    if (acc && !tk && hit) mq.push_back({pc, 32'h0});
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 32'h0, 0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] tgts [4];
    logic [31:0] pc_r, tg_r, pt_r;
    bit          hit_r;
    ex_valid_i = 0; ex_pc_i = 0; ex_taken_i = 0; ex_target_i = 0;
    ex_pred_hit_i = 0; ex_pred_target_i = 0; btb_wr_ready_i = 0;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    check_all_zero("por");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Mispredicted taken branch (BTB miss)
    step(1, 32'h100, 1, 32'h200, 0, 32'h0, 1);
    check("tp1_redirect", redirect_o, 1);
    check("tp1_redirect_pc", redirect_pc_o, 32'h200);
    check("tp1_wr_valid", update_btb_address_o, 1);
    check("tp1_wr_entry", {pc_ex_o, btb_address_value_o}, {32'h100, 32'h200});
    check("tp1_flush", flush_o, 1);
    idle(3, 1);

    // Mispredicted not-taken branch: invalidation
    step(1, 32'h140, 0, 32'h999, 1, 32'h180, 1);
    check("tp2_redirect_pc", redirect_pc_o, 32'h144);
    check("tp2_wr_entry", {pc_ex_o, btb_address_value_o}, {32'h140, 32'h0});
    idle(3, 1);

    // Correct prediction
    step(1, 32'h180, 1, 32'h300, 1, 32'h300, 1);
    check("tp3_redirect", redirect_o, 0);
    check("tp3_wr_valid", update_btb_address_o, 0);
    check("tp3_flush", flush_o, 0);
    idle(1, 1);

    // Backpressure: four queued writes fill the FIFO
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h400 + 32'(i * 16), 1, 32'h1000 + 32'(i * 16), 0, 32'h0, 0);
      idle(2, 0);
    end
    check("tp4_stall_full", stall_o, 1);
    step(1, 32'h700, 1, 32'h800, 0, 32'h0, 0);
    idle(1, 1);
    check("tp4_stall_drop", stall_o, 0);
    idle(4, 1);

    // Wrong-path branch during flush is ignored; zero target skips the write
    step(1, 32'h880, 0, 32'h0, 1, 32'h900, 1);
    step(1, 32'h900, 1, 32'hA00, 0, 32'h0, 1);
    idle(3, 1);
    step(1, 32'h500, 1, 32'h0, 0, 32'h0, 1);
    check("tp5_redirect_pc", redirect_pc_o, 32'h0);
    check("tp5_wr_valid", update_btb_address_o, 0);
    idle(3, 1);

    // Reset mid-flush with two queued writes
    step(1, 32'h600, 1, 32'h610, 0, 32'h0, 0);
    idle(2, 0);
    step(1, 32'h620, 1, 32'h630, 0, 32'h0, 0);
    check("tp6_queued", update_btb_address_o, 1);
    rst_i = 1'b1;
    #1;
    check_all_zero("tp6_rst");
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    idle(2, 0);

    // Random traffic, including PC wrap at the top of the address space
    tgts[0] = 32'h0; tgts[1] = 32'h200; tgts[2] = 32'h300; tgts[3] = 32'h0;
    for (int i = 0; i < 400; i++) begin
      tgts[3] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pc_r    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 1023), 2'b00};
      tg_r    = tgts[$urandom_range(0, 3)];
      hit_r   = $urandom_range(0, 1) == 1;
      pt_r    = ($urandom_range(0, 1) == 1) ? tg_r : tgts[$urandom_range(0, 3)];
      step($urandom_range(0, 2) != 0, pc_r, $urandom_range(0, 1) == 1, tg_r, hit_r, pt_r,
           $urandom_range(0, 3) == 0);
    end
    idle(8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
